// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M/RV64M multiply/divide unit for the EX stage
// Rev 1.0
// ============================================================================
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            is_muldiv,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] Result
);

   localparam int            CW        = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic [2:0]        r_op;
   logic              r_neg;
   logic [XLEN-1:0]   r_opb;
   logic [2*XLEN-1:0] r_acc;

   logic              w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_neg;
   logic [XLEN-1:0]   w_mag_a, w_mag_b;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_result;
   logic [XLEN:0]     w_sum, w_tmp, w_diff;
   logic [2*XLEN-1:0] w_acc_next, w_prod;
   logic [XLEN-1:0]   w_quo, w_rem, w_step_result;

   assign is_muldiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
   assign stall     = in_valid && is_muldiv && (r_state != DONE);
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

   // Operand decode at acceptance: sign policy and fast-path detection
   always_comb begin
      w_a_signed = !(Funct3 == 3'b011 || Funct3 == 3'b101 || Funct3 == 3'b111);
      w_b_signed = (Funct3 == 3'b000 || Funct3 == 3'b001 ||
                    Funct3 == 3'b100 || Funct3 == 3'b110);
      w_neg_a    = w_a_signed && SrcA[XLEN-1];
      w_neg_b    = w_b_signed && SrcB[XLEN-1];
      w_mag_a    = w_neg_a ? -SrcA : SrcA;
      w_mag_b    = w_neg_b ? -SrcB : SrcB;
      w_neg      = (Funct3[2] && Funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
      w_fast        = 1'b0;
      w_fast_result = '0;
      if (Funct3[2] && (SrcB == '0)) begin
         w_fast        = 1'b1;
         w_fast_result = Funct3[1] ? SrcA : '1;
      end else if (Funct3[2] && !Funct3[0] && (SrcA == MIN_INT) && (SrcB == '1)) begin
         w_fast        = 1'b1;
         w_fast_result = Funct3[1] ? '0 : MIN_INT;
      end
   end

   // One shift-add (multiply) or restoring-subtract (divide) step
   always_comb begin
      w_sum      = '0;
      w_tmp      = '0;
      w_diff     = '0;
      w_acc_next = r_acc;
      if (!r_op[2]) begin
         w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
         w_acc_next = {w_sum, r_acc[XLEN-1:1]};
      end else begin
         w_tmp  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
         w_diff = w_tmp - {1'b0, r_opb};
         if (!w_diff[XLEN])
            w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
         else
            w_acc_next = {w_tmp[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
   end

   always_comb begin
      w_prod = r_neg ? -w_acc_next : w_acc_next;
      w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
      w_rem  = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
      case (r_op)
         3'b000:                 w_step_result = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_step_result = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_step_result = w_quo;
         default:                w_step_result = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_op    <= '0;
         r_neg   <= 1'b0;
         r_opb   <= '0;
         r_acc   <= '0;
         Result  <= '0;
      end else if (flush) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && is_muldiv) begin
                  r_op    <= Funct3;
                  r_neg   <= w_neg;
                  r_opb   <= w_mag_b;
                  r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                  r_count <= '0;
                  if (w_fast) begin
                     Result  <= w_fast_result;
                     r_state <= DONE;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_acc   <= w_acc_next;
               r_count <= r_count + 1'b1;
               if (r_count == LAST_STEP) begin
                  Result  <= w_step_result;
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed + randomized self-checking bench for muldiv_unit
// Rev 1.0
// ============================================================================
module tb_muldiv_unit;

   localparam int XLEN = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [1:0]      ALUOp = 2'b00;
   logic [6:0]      Funct7 = 7'd0;
   logic [2:0]      Funct3 = 3'd0;
   logic            in_valid = 1'b0;
   logic            flush = 1'b0;
   logic [XLEN-1:0] SrcA = '0;
   logic [XLEN-1:0] SrcB = '0;
   logic            is_muldiv, stall, busy, done;
   logic [XLEN-1:0] Result;

   int checks = 0;
   int errors = 0;
   int cycle_count = 0;
   int start_cycle = 0;
   int done_cycle = 0;
   logic [31:0] last_exp = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
      .in_valid(in_valid), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
      .is_muldiv(is_muldiv), .stall(stall), .busy(busy), .done(done), .Result(Result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle_count <= cycle_count + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result computed with plain wide arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      case (f3)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
      return XLEN + 1;
   endfunction

   // Present an M instruction in a new cycle 0 and check cycle-0 outputs
   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
      @(posedge clk); #1;
      ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
      SrcA = a; SrcB = b; in_valid = 1'b1;
      start_cycle = cycle_count;
      @(negedge clk);
      check({tag, " c0 stall"}, stall, 1);
      check({tag, " c0 done"}, done, 0);
   endtask

   // Follow the op to its done pulse; operands churn after acceptance
   task automatic wait_done(input int lat, input logic [31:0] exp, input string tag);
      int  c = 0;
      bit  seen = 0;
      bit  ctl_ok = 1;
      while (!seen && c < 45) begin
         @(posedge clk); #1;
         c++;
         SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom_range(0, 7));
         @(negedge clk);
         if (done) seen = 1;
         else if (!stall || !busy) ctl_ok = 0;
      end
      done_cycle = cycle_count;
      check({tag, " done cycle"}, 64'(c), 64'(lat));
      check({tag, " result"}, Result, exp);
      check({tag, " stall/busy before done"}, ctl_ok, 1);
      check({tag, " stall at done"}, stall, 0);
      last_exp = exp;
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      start_op(f3, a, b, tag);
      wait_done(ref_latency(f3, a, b), exp, tag);
   endtask

   initial begin
      int b2b_start;
      logic [2:0]  f3;
      logic [31:0] a, b;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst result", Result, 0);
      check("rst stall", stall, 0);
      reset = 1'b1;

      // Directed values
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
      run_op(3'b001, MINV, MINV, 32'h4000_0000, "MULH");
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7%2");
      run_op(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, "DIVU /0");
      run_op(3'b110, MINV, 32'hFFFF_FFFF, 32'h0, "REM ovf");
      run_op(3'b100, MINV, 32'hFFFF_FFFF, MINV, "DIV ovf");

      // Back-to-back MULs
      start_op(3'b000, 32'd11, 32'd13, "b2b1");
      b2b_start = start_cycle;
      wait_done(XLEN + 1, 32'd143, "b2b1");
      start_op(3'b000, 32'hFFFF_FFFF, 32'd9, "b2b2");
      check("b2b second accept cycle", 64'(start_cycle - b2b_start), 64'd34);
      wait_done(XLEN + 1, 32'hFFFF_FFF7, "b2b2");
      check("b2b second done cycle", 64'(done_cycle - b2b_start), 64'd67);

      // Flush in cycle 10 of a DIV, then MUL 3*5 in cycle 11
      start_op(3'b100, 32'd100, 32'd7, "flush");
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      flush = 1'b0;
      Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5;
      @(negedge clk);
      check("flush busy c11", busy, 0);
      check("flush done c11", done, 0);
      check("flush result held", Result, last_exp);
      wait_done(XLEN + 1, 32'd15, "post-flush MUL");
      check("post-flush done cycle", 64'(done_cycle - start_cycle), 64'd44);

      // Reset during cycle 20 of a MUL
      start_op(3'b000, 32'd1234, 32'd5678, "rstmid");
      for (int k = 1; k < 20; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      Funct3 = 3'b011; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
      #1;
      check("rstmid busy", busy, 0);
      check("rstmid done", done, 0);
      check("rstmid result", Result, 0);
      check("rstmid stall pending", stall, 1);
      @(negedge clk);
      reset = 1'b1;
      wait_done(XLEN + 1, ref_model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), "rstmid new");

      // Non-M instruction leaves the unit alone
      @(posedge clk); #1;
      ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ADD is_muldiv", is_muldiv, 0);
         check("ADD stall", stall, 0);
         check("ADD busy", busy, 0);
         @(posedge clk); #1;
      end

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = MINV; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'($urandom_range(0, 20));
            default: ;
         endcase
         run_op(f3, a, b, ref_model(f3, a, b), $sformatf("rand%0d f3=%0d", i, f3));
      end

      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
